cipher_out_buffer: RTL and testbench
====================================

# cipher_out_buffer

Result buffer directly downstream of the encrypt core's ciphertext output, parallel to the host I/O interface. It captures each 128-bit `Ciphertext` block on `c_ready` into a small FIFO and serializes it to the host one byte per read strobe, most-significant byte first. `FULL` tells the encrypt core to stop producing blocks, so finished results are never silently lost.

## Interface
- `DEPTH`, 4: block capacity; power of two, ≥ 2.
- `AW`, 2: pointer width, log2(`DEPTH`).
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `CLR`  in  1  synchronous flush, driven from the core reset request (`t_reset`).
- `Ciphertext`  in  128  encrypted block from the encrypt core.
- `c_ready`  in  1  write strobe; one cycle per block.
- `RD`  in  1  host byte-read strobe; one cycle per byte.
- `DOUT`  out  8  current head byte.
- `DVALID`  out  1  FIFO non-empty; `DOUT` meaningful.
- `BLK_DONE`  out  1  one-cycle pulse after the 16th byte of a block is consumed.
- `FULL`  out  1  `LEVEL == DEPTH`; stall request to the encrypt core.
- `LEVEL`  out  AW+1  number of blocks stored, 0..`DEPTH`.
- `OVF`  out  1  sticky overflow flag: a block was dropped.

## Operation
- **Storage:** `DEPTH` x 128-bit registers, plus `wr_ptr`, `rd_ptr` (AW bits, wrapping modulo `DEPTH`), `LEVEL`, and a 4-bit `byte_idx`.
- **Write:**
  - `c_ready` with `LEVEL < DEPTH`: store `Ciphertext` at `wr_ptr`, then `wr_ptr`+1.
  - `c_ready` with `LEVEL == DEPTH` and no simultaneous pop: block dropped, `OVF` <= 1.
- **Read:**
  - `RD` with `DVALID` = 1: `byte_idx`+1.
  - `RD` with `DVALID` = 0: ignored, no state change.
- **Pop:** `RD` when `byte_idx` == 15.
  - `byte_idx` <= 0, `rd_ptr`+1, `LEVEL`-1.
  - `BLK_DONE` pulses on the next cycle.
- **`DOUT`:** `mem[rd_ptr][127-8*byte_idx -: 8]`.
  - Combinational from registers only, no input-to-output path.
  - Forced to 8'h00 when `LEVEL == 0`.
- **Simultaneous write and pop:**
  - Both happen; `LEVEL` unchanged.
  - At `LEVEL == DEPTH` the write is accepted, no overflow.
  - At `LEVEL == 0` a pop cannot occur, so the write simply lands.
- **`CLR`:**
  - Zeroes pointers, `LEVEL`, `byte_idx`, `OVF` and `BLK_DONE`.
  - Has priority over a same-cycle `c_ready` and `RD`; both are discarded.
  - Memory contents are not cleared.
- **`RST`:** same clearing as `CLR`, plus memory to 0; acts immediately, asynchronously.
- **Reset value of every output:** `DOUT` = 0, `DVALID` = 0, `BLK_DONE` = 0, `FULL` = 0, `LEVEL` = 0, `OVF` = 0.
- **Arithmetic:**
  - Pointers wrap naturally at AW bits.
  - `LEVEL` never exceeds `DEPTH` and never underflows.
  - `byte_idx` wraps 15 -> 0 only on a pop.

## Timing
- **Write latency:** `c_ready` sampled at edge N; `DVALID`, `LEVEL`, `FULL` and `DOUT` reflect the new block after edge N.
- **Read latency:** `RD` at edge N; the next byte appears on `DOUT` after edge N.
  - Host samples `DOUT` before issuing `RD`.
  - Back-to-back `RD` every cycle is legal: 16 cycles per block.
- **`BLK_DONE`:** registered; high for exactly the cycle after the popping edge.
- **`FULL`:**
  - Rises in the cycle after the write that fills the FIFO.
  - Falls in the cycle after a pop, unless a write occurred at the same edge.
  - The encrypt core must not pulse `c_ready` while `FULL` = 1, except at the same edge as a pop; otherwise `OVF` is set.
- **`OVF`:** set the cycle after the dropped write; held until `CLR` or `RST`.
- **Reset mid-block:** a partially read block is discarded; the next written block is read from byte 0.

## Test plan
- **Reset and single block:**
  - Stimulus: assert `RST`, then write 128'h00112233445566778899AABBCCDDEEFF, then 16 `RD`.
  - Required: all outputs 0 after `RST`; `DOUT` sequence 00, 11, ..., FF; `BLK_DONE` one pulse; `LEVEL` 1 -> 0; `DVALID` falls.
- **Fill, overflow and wrap-around:**
  - Stimulus: write 5 distinct blocks, no reads; then read all blocks.
  - Required: `FULL` after the 4th; 5th dropped; `OVF` = 1; `LEVEL` = 4; readout returns blocks 1-4 in order.
  - Stimulus: 8 more write/read cycles.
  - Required: correct data through pointer wrap.
- **Simultaneous write and pop at full:**
  - Stimulus: `LEVEL` = 4; `c_ready` on the same edge as the 16th `RD`.
  - Required: `LEVEL` stays 4, `OVF` stays 0, new block is read last.
- **Read when empty:**
  - Stimulus: 3 `RD` with `LEVEL` = 0, then write a block.
  - Required: `DOUT` = 00 throughout the empty `RD`s; first byte after the write is the block MSB, i.e. the empty reads had no effect.
- **`CLR` mid-block:**
  - Stimulus: 2 blocks stored, 5 bytes read, then `CLR` together with `c_ready`.
  - Required: `LEVEL` = 0, `OVF` = 0, `DVALID` = 0, the same-cycle block is discarded; the next write is read from byte 0.
- **Async `RST` mid-operation:**
  - Stimulus: assert `RST` between clock edges with 3 blocks stored.
  - Required: all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/cipher_out_buffer.sv
// Ciphertext result FIFO: captures 128-bit blocks from the encrypt core
// and serves them to the host one byte per read strobe, MSB first.
module cipher_out_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR,
  input  logic [127:0]  Ciphertext,
  input  logic          c_ready,
  input  logic          RD,
  output logic [7:0]    DOUT,
  output logic          DVALID,
  output logic          BLK_DONE,
  output logic          FULL,
  output logic [AW:0]   LEVEL,
  output logic          OVF
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic [3:0]    idx_q;
  logic          ovf_q;
  logic          done_q;

  logic          not_empty;
  logic          rd_en;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [6:0]    sel;

  assign not_empty = (level_q != '0);
  assign rd_en     = RD & not_empty;
  assign pop       = rd_en & (idx_q == 4'hf);
  // A write at full is still taken when a pop frees a slot on the same edge.
  assign wr_en     = c_ready & ((level_q != FULL_LVL) | pop);
  assign drop      = c_ready & ~wr_en;

  always_comb begin
    level_d = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= Ciphertext;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_en) idx_q <= idx_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) ovf_q <= 1'b1;
      level_q <= level_d;
      done_q  <= pop;
    end
  end

  // Byte 0 is the top byte, so the bit offset is 8*(15-idx).
  assign sel = {~idx_q, 3'b000};

  always_comb begin
    DOUT = '0;
    if (not_empty) DOUT = mem_q[rd_ptr_q][sel +: 8];
  end

  assign DVALID   = not_empty;
  assign BLK_DONE = done_q;
  assign FULL     = (level_q == FULL_LVL);
  assign LEVEL    = level_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_cipher_out_buffer.sv
// Self-checking bench for cipher_out_buffer against a queue-based
// model of the block FIFO and byte serializer.
module tb_cipher_out_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CLR = 1'b0;
  logic [127:0]  Ciphertext = '0;
  logic          c_ready = 1'b0;
  logic          RD = 1'b0;
  logic [7:0]    DOUT;
  logic          DVALID;
  logic          BLK_DONE;
  logic          FULL;
  logic [AW:0]   LEVEL;
  logic          OVF;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [127:0] q[$];
  int           m_idx = 0;
  bit           m_ovf = 0;
  bit           m_bd  = 0;

  cipher_out_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .Ciphertext(Ciphertext), .c_ready(c_ready), .RD(RD),
    .DOUT(DOUT), .DVALID(DVALID), .BLK_DONE(BLK_DONE),
    .FULL(FULL), .LEVEL(LEVEL), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [14:0] exp_vec();
    logic [7:0] d;
    d = 8'h00;
    if (q.size() > 0) d = 8'(q[0] >> (8 * (15 - m_idx)));
    return {d, logic'(q.size() > 0), logic'(m_bd),
            logic'(q.size() == DEPTH), 3'(q.size()), logic'(m_ovf)};
  endfunction

  function automatic logic [14:0] act_vec();
    return {DOUT, DVALID, BLK_DONE, FULL, LEVEL, OVF};
  endfunction

  task automatic mdl_reset();
    q.delete();
    m_idx = 0;
    m_ovf = 0;
    m_bd  = 0;
  endtask

  task automatic mdl_step(bit cr, logic [127:0] data, bit rd, bit clr);
    bit pop;
    pop = 0;
    m_bd = 0;
    if (clr) begin
      mdl_reset();
      return;
    end
    if (rd && q.size() > 0) begin
      if (m_idx == 15) pop = 1;
      else m_idx++;
    end
    if (cr) begin
      if (q.size() < DEPTH || pop) q.push_back(data);
      else m_ovf = 1;
    end
    if (pop) begin
      void'(q.pop_front());
      m_idx = 0;
      m_bd  = 1;
    end
  endtask

  // One clock: drive, take the edge, update the model, release inputs.
  task automatic cyc(bit cr, logic [127:0] data, bit rd, bit clr);
    c_ready    = cr;
    Ciphertext = data;
    RD         = rd;
    CLR        = clr;
    @(posedge CLK);
    mdl_step(cr, data, rd, clr);
    #1;
    c_ready = 1'b0;
    RD      = 1'b0;
    CLR     = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2;
    checks++;
    if (act_vec() !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", act_vec(), 15'h0);
    end
    @(negedge CLK);
    RST = 1'b0;
    mdl_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single_block();
    logic [127:0] blk;
    int pulses;
    blk = 128'h00112233445566778899AABBCCDDEEFF;
    pulses = 0;
    cyc(1, blk, 0, 0);
    checks++;
    if (LEVEL !== 3'd1 || DVALID !== 1'b1) begin
      failures++;
      $display("FAIL single_write level=%0d dvalid=%b want 1/1", LEVEL, DVALID);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (DOUT !== 8'(8'h11 * i)) begin
        failures++;
        $display("FAIL single_byte%0d got=%h want=%h", i, DOUT, 8'(8'h11 * i));
      end
      cyc(0, '0, 1, 0);
      if (BLK_DONE) pulses++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_step%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    cyc(0, '0, 0, 0);
    if (BLK_DONE) pulses++;
    checks++;
    if (pulses != 1 || LEVEL !== 3'd0 || DVALID !== 1'b0) begin
      failures++;
      $display("FAIL single_end pulses=%0d level=%0d dvalid=%b want 1/0/0",
               pulses, LEVEL, DVALID);
    end
  endtask

  task automatic drain_check(string nm, int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      cyc(0, '0, 1, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL %s_rd%0d got=%h want=%h", nm, i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_fill_overflow_wrap();
    logic [127:0] blks[5];
    for (int i = 0; i < 5; i++)
      blks[i] = {$urandom, $urandom, $urandom, 24'($urandom), 8'(i)};
    for (int i = 0; i < 5; i++) begin
      cyc(1, blks[i], 0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL fill_wr%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    checks++;
    if (OVF !== 1'b1 || LEVEL !== 3'd4 || FULL !== 1'b1) begin
      failures++;
      $display("FAIL fill_state ovf=%b level=%0d full=%b want 1/4/1", OVF, LEVEL, FULL);
    end
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (DOUT !== 8'(blks[b] >> (8 * (15 - i)))) begin
          failures++;
          $display("FAIL fill_blk%0d_byte%0d got=%h want=%h", b, i, DOUT,
                   8'(blks[b] >> (8 * (15 - i))));
        end
        cyc(0, '0, 1, 0);
      end
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL fill_drained got=%h want=%h", act_vec(), exp_vec());
    end
    for (int k = 0; k < 8; k++) begin
      cyc(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
      drain_check("wrap", 16);
    end
    cyc(0, '0, 0, 1);
    checks++;
    if (OVF !== 1'b0) begin
      failures++;
      $display("FAIL wrap_clr_ovf got=%b want=0", OVF);
    end
  endtask

  task automatic test_simul_full();
    logic [127:0] nb;
    for (int i = 0; i < 4; i++)
      cyc(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    drain_check("simul_pre", 15);
    nb = {$urandom, $urandom, $urandom, $urandom};
    cyc(1, nb, 1, 0);
    checks++;
    if (LEVEL !== 3'd4 || OVF !== 1'b0 || BLK_DONE !== 1'b1) begin
      failures++;
      $display("FAIL simul_edge level=%0d ovf=%b done=%b want 4/0/1",
               LEVEL, OVF, BLK_DONE);
    end
    drain_check("simul_post", 48);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (DOUT !== 8'(nb >> (8 * (15 - i)))) begin
        failures++;
        $display("FAIL simul_last_byte%0d got=%h want=%h", i, DOUT,
                 8'(nb >> (8 * (15 - i))));
      end
      cyc(0, '0, 1, 0);
    end
  endtask

  task automatic test_read_empty();
    logic [127:0] blk;
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 0);
      checks++;
      if (DOUT !== 8'h00 || DVALID !== 1'b0) begin
        failures++;
        $display("FAIL empty_rd%0d dout=%h dvalid=%b want 00/0", i, DOUT, DVALID);
      end
    end
    blk = {8'hA5, $urandom, $urandom, $urandom, 24'($urandom)};
    cyc(1, blk, 0, 0);
    checks++;
    if (DOUT !== 8'hA5) begin
      failures++;
      $display("FAIL empty_first got=%h want=a5", DOUT);
    end
    drain_check("empty", 16);
  endtask

  task automatic test_clr_mid_block();
    cyc(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    cyc(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    drain_check("clr_pre", 5);
    cyc(1, {$urandom, $urandom, $urandom, $urandom}, 1, 1);
    checks++;
    if (LEVEL !== 3'd0 || OVF !== 1'b0 || DVALID !== 1'b0 || DOUT !== 8'h00) begin
      failures++;
      $display("FAIL clr_state level=%0d ovf=%b dvalid=%b dout=%h want 0/0/0/00",
               LEVEL, OVF, DVALID, DOUT);
    end
    cyc(1, {8'h3C, $urandom, $urandom, $urandom, 24'($urandom)}, 0, 0);
    checks++;
    if (DOUT !== 8'h3C || LEVEL !== 3'd1) begin
      failures++;
      $display("FAIL clr_next dout=%h level=%0d want 3c/1", DOUT, LEVEL);
    end
    drain_check("clr_post", 16);
  endtask

  task automatic test_async_rst();
    for (int i = 0; i < 3; i++)
      cyc(1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    drain_check("arst_pre", 2);
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if (act_vec() !== 15'h0) begin
      failures++;
      $display("FAIL arst_immediate got=%h want=%h", act_vec(), 15'h0);
    end
    mdl_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    cyc(1, {8'h5A, $urandom, $urandom, $urandom, 24'($urandom)}, 0, 0);
    checks++;
    if (DOUT !== 8'h5A || LEVEL !== 3'd1) begin
      failures++;
      $display("FAIL arst_next dout=%h level=%0d want 5a/1", DOUT, LEVEL);
    end
    drain_check("arst_post", 16);
  endtask

  task automatic test_random();
    bit cr, rd, clr;
    for (int i = 0; i < 600; i++) begin
      cr  = ($urandom_range(0, 99) < 12);
      rd  = ($urandom_range(0, 99) < 80);
      clr = ($urandom_range(0, 299) == 0);
      cyc(cr, {$urandom, $urandom, $urandom, $urandom}, rd, clr);
      checks++;
      if (act_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rand_cyc%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_fill_overflow_wrap();
    test_simul_full();
    test_read_empty();
    test_clr_mid_block();
    test_async_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
